// File: rtl/swi_mem_cmd.sv
// -----------------------------------------------------------------------------
// swi_mem_cmd
//
// Switch conditioning and command generation for the board-level scratch
// memory. The eight slide switches are synchronized and debounced. A rising
// edge on the debounced write switch produces a single-cycle write strobe that
// carries the address and data latched at that moment. While the scan switch
// is on, the read address steps through every word so the LEDs can show the
// whole memory without touching the address switches.
//
// Ports:
//   clk_2        board clock, everything runs on the rising edge
//   reset_n      asynchronous active-low reset
//   SWI[7:0]     raw switches: [0] scan enable, [1] write request,
//                [3:2] address, [7:4] write data
//   wr_en        one-cycle write strobe to the memory
//   addr         memory address (latched write address, scan address,
//                or the live debounced address switches)
//   wdata        memory write data
//   scan_active  high while the read address is auto-scanning
//   db_swi[7:0]  debounced switch vector for LED/LCD debug
// -----------------------------------------------------------------------------
module swi_mem_cmd #(
  parameter int ADDR_WIDTH      = 2,
  parameter int DATA_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_HOLD       = 8
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  input  logic [7:0]            SWI,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  scan_active,
  output logic [7:0]            db_swi
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2,
    SCAN  = 2'd3
  } state_t;

  logic [7:0]            sync_q1;
  logic [7:0]            sync_q2;
  logic [CNT_W-1:0]      db_cnt [8];
  logic                  db_q1;
  logic                  wr_rise;

  state_t                state;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic [HOLD_W-1:0]     hold_cnt;

  // Switch fields as seen by the memory side, resized to the memory widths.
  logic [ADDR_WIDTH-1:0] sw_addr;
  logic [DATA_WIDTH-1:0] sw_data;

  assign sw_addr = ADDR_WIDTH'(db_swi[3:2]);
  assign sw_data = DATA_WIDTH'(db_swi[7:4]);

  // Two-flop synchronizer on every switch bit.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= SWI;
      sync_q2 <= sync_q1;
    end
  end

  // Per-bit debounce: a bit only changes after it has disagreed with the
  // debounced value for DEBOUNCE_CYCLES consecutive synchronized samples.
  // Any sample that agrees again restarts the count, so short pulses vanish.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      db_swi <= '0;
      for (int i = 0; i < 8; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync_q2[i] == db_swi[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_swi[i] <= sync_q2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Previous debounced write switch, for rising-edge detection.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      db_q1 <= 1'b0;
    end else begin
      db_q1 <= db_swi[1];
    end
  end

  assign wr_rise = db_swi[1] & ~db_q1;

  // Command FSM. wr_en and scan_active are registered alongside the state so
  // they are exactly the WRITE and SCAN state flags with no decode glitches.
  // A write rise always beats the scan switch, both from IDLE and from SCAN.
  // HOLD waits for the write switch to drop so a held switch cannot re-strobe.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_en       <= 1'b0;
      scan_active <= 1'b0;
      lat_addr    <= '0;
      lat_data    <= '0;
      scan_addr   <= '0;
      hold_cnt    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_rise) begin
            state    <= WRITE;
            wr_en    <= 1'b1;
            lat_addr <= sw_addr;
            lat_data <= sw_data;
          end else if (db_swi[0]) begin
            state       <= SCAN;
            scan_active <= 1'b1;
            scan_addr   <= '0;
            hold_cnt    <= '0;
          end
        end

        WRITE: begin
          state <= HOLD;
        end

        HOLD: begin
          if (!db_swi[1]) begin
            state <= IDLE;
          end
        end

        SCAN: begin
          if (wr_rise) begin
            state       <= WRITE;
            wr_en       <= 1'b1;
            scan_active <= 1'b0;
            lat_addr    <= sw_addr;
            lat_data    <= sw_data;
          end else if (!db_swi[0]) begin
            state       <= IDLE;
            scan_active <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            // Address wraps naturally at 2**ADDR_WIDTH.
            scan_addr <= scan_addr + ADDR_WIDTH'(1);
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        default: begin
          state       <= IDLE;
          scan_active <= 1'b0;
        end
      endcase
    end
  end

  // Address/data source follows the state: live switches when idle, the
  // latched command during WRITE/HOLD, the scan counter while scanning.
  always_comb begin
    addr  = sw_addr;
    wdata = sw_data;
    case (state)
      WRITE, HOLD: begin
        addr  = lat_addr;
        wdata = lat_data;
      end
      SCAN: begin
        addr = scan_addr;
      end
      default: begin
      end
    endcase
  end

endmodule
